// File: rtl/mips_ifetch.sv
// mips_ifetch: MIPS32 instruction fetch with prefetch FIFO, redirect and HLT stop
module mips_ifetch #(
  parameter int AW       = 10,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_npc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] pc, inf_addr;
  logic          inflight, halt_seen, pop, hlt_pop, room;
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] fifo_npc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  assign pop       = id_valid && id_ready;
  assign hlt_pop   = pop && id_instr[31:26] == 6'h3f;
  // the slot freed by this cycle's pop can take the word requested now
  assign room      = ({1'b0, count} + (CW+1)'(inflight)) < ((CW+1)'(DEPTH) + (CW+1)'(pop));
  assign imem_en   = !rst && !halted && !halt_seen && !redirect && room;
  assign imem_addr = pc;
  assign id_valid  = count != '0 && !redirect && !halted;
  assign id_instr  = fifo_instr[rd_ptr];
  assign id_npc    = fifo_npc[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= AW'(RESET_PC);
      inf_addr  <= '0;
      inflight  <= 1'b0;
      halt_seen <= 1'b0;
      halted    <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_npc[i]   <= '0;
      end
    end else if (redirect && !halted) begin
      pc        <= redirect_pc;
      inflight  <= 1'b0;
      halt_seen <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (hlt_pop) begin
      halted   <= 1'b1;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        pc       <= pc + AW'(1);
        inf_addr <= pc;
      end
      if (inflight) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_npc[wr_ptr]   <= inf_addr + AW'(1);
        wr_ptr             <= wr_ptr + PW'(1);
        if (imem_rdata[31:26] == 6'h3f) halt_seen <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(inflight) - CW'(pop);
    end
  end
endmodule

// File: doc/mips_ifetch.md
# mips_ifetch

Instruction-fetch stage for the MIPS32 pipelined `cpu`. The block owns the program counter and issues word reads to the synchronous instruction memory. It buffers the returned words in a small prefetch FIFO and hands them to decode over a valid/ready handshake. It also accepts branch redirects from downstream and stops fetching at `HLT` (opcode `6'h3f`, e.g. `32'hfc000000`), replacing the hand-inserted dummy instructions and manual `PC`/`HALTED` pokes with a self-contained front end.

## Interface
Reset is synchronous and active-high. The block has one clock, `clk`, and one reset, `rst`.

Parameters:
- `AW`, default 10: word-address width. PC is a word index; +1 means the next instruction.
- `DEPTH`, default 2: prefetch FIFO entries. Must be a power of two, ≥2.
- `RESET_PC`, default 0: fetch address after reset.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_en`  out  1: read request this cycle.
- `imem_addr`  out  AW: word address of the request.
- `imem_rdata`  in  32: read data, valid exactly one cycle after the request.
- `id_valid`  out  1: `id_instr`/`id_npc` hold a valid instruction.
- `id_ready`  in  1: decode accepts this cycle.
- `id_instr`  out  32: instruction at the FIFO head.
- `id_npc`  out  AW: head instruction's address + 1, mod 2^AW.
- `redirect`  in  1: branch taken / flush, one-cycle pulse.
- `redirect_pc`  in  AW: new fetch address, sampled when `redirect`=1.
- `halted`  out  1: an `HLT` was accepted by decode. Sticky until `rst`.

## Operation
**Reset values:**
- `imem_en`=0, `imem_addr`=`RESET_PC`.
- `id_valid`=0, `id_instr`=0, `id_npc`=0.
- `halted`=0.
- FIFO empty; no request in flight; `halt_seen`=0.

**State:** `pc`, FIFO storage (instr + npc per entry), `count`, `inflight` (1 bit, with its address), `halt_seen`, `halted`.

**Issue rule:**
- `imem_en` = !halted && !halt_seen && !redirect && (count + inflight − pop < DEPTH).
- pop = id_valid && id_ready.
- `imem_addr` = pc. On issue, pc ← pc+1 (wraps mod 2^AW), and the issued address is latched with `inflight`.

**Response:**
- The cycle after an issue, `imem_rdata` is pushed with npc = issued address + 1, unless cancelled by a redirect.
- A push of a word with `[31:26]`=`6'h3f` sets `halt_seen`.

**Output:**
- `id_valid` = count>0 && !redirect && !halted.
- `id_instr`/`id_npc` come from the FIFO head.
- Push and pop in the same cycle leave count unchanged. The FIFO never overflows, which the issue rule guarantees.

**Halt:**
- Popping an `HLT` word sets `halted` on the following edge.
- After that, no issue occurs and `id_valid` stays 0.
- Any other queued words behind the `HLT` are dropped.

**Redirect** (has priority over everything except `rst`):
- In the redirect cycle: FIFO is flushed, the in-flight response is discarded, `halt_seen` is cleared, and pc ← `redirect_pc`.
- No issue occurs in the redirect cycle. `redirect_pc` issues the next cycle.
- Redirect while `halted`=1 is ignored.

**Reset mid-operation:** all state returns to reset values on that edge. A pending response arriving after reset is ignored.

## Timing
- First edge with `rst`=0 (cycle 0): `imem_en`=1, addr=`RESET_PC`.
- Cycle 1: data pushed.
- Cycle 2: `id_valid`=1. Fetch-to-decode latency is 2 cycles, with no bypass.
- Steady state with `id_ready`=1: one instruction per cycle.
- Redirect in cycle t: request for `redirect_pc` in t+1, `id_valid` in t+3.
- `halted` rises the cycle after the `HLT` handshake.

## Test plan
Common setup: memory holds MEM[0..3] = `2801000a`, `28020014`, `00222000`, `fc000000`; MEM[0x20] = `0ce77800`.

1. **Streaming:** reset, `id_ready`=1.
   - Expect handshakes on cycles 2..5 delivering `2801000a`/npc1, `28020014`/npc2, `00222000`/npc3, `fc000000`/npc4.
   - `halted`=1 on cycle 6; `imem_en` never high after the `HLT` is pushed.
2. **Backpressure:** hold `id_ready`=0 for cycles 0..8.
   - `imem_en` drops once count+inflight=2; `id_instr` holds `2801000a`.
   - On release, the same four words arrive in order, with no duplicates and none missing.
3. **Redirect:** `redirect`=1 with `redirect_pc`=0x20 while count=2.
   - `id_valid`=0 in that cycle; the next request address is 0x20.
   - Next delivered word is `0ce77800`/npc 0x21, with no stale words from addresses 0..3.
4. **Speculative HLT:** `id_ready`=0 until `fc000000` is queued, then pulse `redirect` to 0x20.
   - `halted` stays 0, fetch resumes at 0x20, and `0ce77800` is delivered.
5. **Wrap:** `RESET_PC`=2^AW−1 (0x3FF).
   - Requests go to 0x3FF then 0x000; the first `id_npc` is 0x000.
6. **Reset mid-stream:** assert `rst` for one cycle while count=2 and a request is in flight.
   - Next cycle: `id_valid`=0 and `halted`=0; fetch restarts at `RESET_PC` and the stream matches scenario 1.
